// File: rtl/sub_result_if.sv
// Handshake bundle between the SUB unit, the result stage and the writeback consumer.
interface sub_result_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_opA;
  logic [WIDTH-1:0] in_opB;
  logic [WIDTH-1:0] in_result;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_neg;
  logic             out_borrow;
  logic             out_ovf;
  logic [CNT_W-1:0] out_count;

  // master: SUB datapath plus consumer side; slave: the result stage itself
  modport master (
    output in_valid, in_opA, in_opB, in_result, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_neg, out_borrow, out_ovf, out_count
  );
  modport slave (
    input  in_valid, in_opA, in_opB, in_result, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_neg, out_borrow, out_ovf, out_count
  );
endinterface

// File: rtl/sub_result_stage.sv
// Two-entry result buffer behind the SUB unit: captures the difference, derives
// zero/neg/borrow/ovf flags at push time, and counts delivered results.
module sub_result_stage #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  sub_result_if.slave bus
);
  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_e;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             neg;
    logic             borrow;
    logic             ovf;
  } entry_t;

  occ_e             state_q, state_d;
  entry_t           head_q, tail_q, new_e;
  logic             push, pop;
  logic             ld_head_new, ld_head_tail, ld_tail;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    new_e.result = bus.in_result;
    new_e.zero   = (bus.in_result == '0);
    new_e.neg    = bus.in_result[MSB];
    new_e.borrow = (bus.in_opA < bus.in_opB);
    new_e.ovf    = (bus.in_opA[MSB] != bus.in_opB[MSB]) &&
                   (bus.in_result[MSB] != bus.in_opA[MSB]);
  end

  // in_ready comes from occupancy only, so upstream never waits on out_ready
  assign bus.in_ready  = ~rst & (state_q != FULL);
  assign bus.out_valid = (state_q != EMPTY);
  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d      = state_q;
    ld_head_new  = 1'b0;
    ld_head_tail = 1'b0;
    ld_tail      = 1'b0;
    case (state_q)
      EMPTY: if (push) begin
        state_d     = ONE;
        ld_head_new = 1'b1;
      end
      ONE: case ({push, pop})
        2'b10: begin
          state_d = FULL;
          ld_tail = 1'b1;
        end
        2'b01:   state_d = EMPTY;
        2'b11:   ld_head_new = 1'b1;
        default: state_d = ONE;
      endcase
      FULL: if (pop) begin
        state_d      = ONE;
        ld_head_tail = 1'b1;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // head is the output register; it keeps the last popped entry while empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (ld_head_new)       head_q <= new_e;
      else if (ld_head_tail) head_q <= tail_q;
      if (ld_tail)           tail_q <= new_e;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt_q <= '0;
    else if (pop) cnt_q <= cnt_q + 1'b1;
  end

  assign bus.out_result = head_q.result;
  assign bus.out_zero   = head_q.zero;
  assign bus.out_neg    = head_q.neg;
  assign bus.out_borrow = head_q.borrow;
  assign bus.out_ovf    = head_q.ovf;
  assign bus.out_count  = cnt_q;
endmodule

// File: tb/tb_sub_result_stage.sv
// Directed bench for sub_result_stage: flag vectors from a table plus handshake corner sequences.
module tb_sub_result_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   exp_cnt = 0;

  sub_result_if #(.WIDTH(8), .CNT_W(8)) bus();

  sub_result_stage #(.WIDTH(8), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] opa;
    logic [7:0] opb;
    logic [7:0] res;
    logic [3:0] flags;  // {zero, neg, borrow, ovf}
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [7:0] r);
    bus.in_valid  = v;
    bus.in_opA    = a;
    bus.in_opB    = b;
    bus.in_result = r;
  endtask

  function automatic logic [3:0] flags();
    return {bus.out_zero, bus.out_neg, bus.out_borrow, bus.out_ovf};
  endfunction

  initial begin
    vecs[0] = '{8'd15,  8'd3,   8'd12,  4'b0000};
    vecs[1] = '{8'd3,   8'd5,   8'd254, 4'b0110};
    vecs[2] = '{8'h80,  8'h01,  8'h7F,  4'b0001};
    vecs[3] = '{8'd5,   8'd5,   8'd0,   4'b1000};
    vecs[4] = '{8'h7F,  8'hFF,  8'h80,  4'b0111};
    vecs[5] = '{8'h00,  8'h01,  8'hFF,  4'b0110};

    drive(1'b0, 8'd0, 8'd0, 8'd0);
    bus.out_ready = 1'b0;
    #12;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_result", bus.out_result, 0);
    check("rst_flags", flags(), 0);
    check("rst_count", bus.out_count, 0);
    rst = 1'b0;
    #1;
    check("rel_in_ready", bus.in_ready, 1);

    // table: push one, see it next cycle, pop it
    bus.out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vecs[i].opa, vecs[i].opb, vecs[i].res);
      step();
      drive(1'b0, 8'd0, 8'd0, 8'd0);
      check($sformatf("v%0d_valid", i), bus.out_valid, 1);
      check($sformatf("v%0d_result", i), bus.out_result, vecs[i].res);
      check($sformatf("v%0d_flags", i), flags(), vecs[i].flags);
      step();
      exp_cnt++;
      check($sformatf("v%0d_empty", i), bus.out_valid, 0);
      check($sformatf("v%0d_count", i), bus.out_count, exp_cnt);
    end

    // backpressure: fill to FULL, third push ignored, drain in order
    bus.out_ready = 1'b0;
    drive(1'b1, 8'd10, 8'd1, 8'd9);
    step();
    check("bp_ready1", bus.in_ready, 1);
    drive(1'b1, 8'd20, 8'd2, 8'd18);
    step();
    check("bp_ready2", bus.in_ready, 0);
    drive(1'b1, 8'd30, 8'd3, 8'd27);
    step();
    check("bp_ready3", bus.in_ready, 0);
    check("bp_hold", bus.out_result, 9);
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    bus.out_ready = 1'b1;
    check("bp_head1", bus.out_result, 9);
    step();
    exp_cnt++;
    check("bp_head2", bus.out_result, 18);
    check("bp_valid2", bus.out_valid, 1);
    step();
    exp_cnt++;
    check("bp_empty", bus.out_valid, 0);
    check("bp_count", bus.out_count, exp_cnt);

    // ONE state with simultaneous push and pop
    bus.out_ready = 1'b0;
    drive(1'b1, 8'd4, 8'd1, 8'd3);
    step();
    drive(1'b1, 8'd7, 8'd7, 8'd0);
    bus.out_ready = 1'b1;
    step();
    exp_cnt++;
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    check("pp_valid", bus.out_valid, 1);
    check("pp_ready", bus.in_ready, 1);
    check("pp_result", bus.out_result, 0);
    check("pp_zero", bus.out_zero, 1);
    step();
    exp_cnt++;
    check("pp_empty", bus.out_valid, 0);
    check("pp_count", bus.out_count, exp_cnt);

    // reset mid-cycle with two entries buffered
    bus.out_ready = 1'b0;
    drive(1'b1, 8'd50, 8'd1, 8'd49);
    step();
    drive(1'b1, 8'd60, 8'd1, 8'd59);
    step();
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    check("mr_full", bus.in_ready, 0);
    #2;
    rst = 1'b1;
    #1;
    exp_cnt = 0;
    check("mr_valid", bus.out_valid, 0);
    check("mr_count", bus.out_count, 0);
    check("mr_in_ready", bus.in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mr_rel_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    drive(1'b1, 8'd100, 8'd50, 8'd50);
    step();
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    check("mr_result", bus.out_result, 50);
    check("mr_valid2", bus.out_valid, 1);
    step();
    exp_cnt++;
    check("mr_count2", bus.out_count, exp_cnt);

    // streaming push&pop to wrap the counter
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, i[7:0], 8'd0, i[7:0]);
      step();
      if (i > 0) exp_cnt++;
      if (i == 254) check("wr_pre", bus.out_count, exp_cnt % 256);
      if (i > 0 && i % 64 == 0) check($sformatf("wr_head%0d", i), bus.out_result, i);
    end
    check("wr_zero", bus.out_count, exp_cnt % 256);
    drive(1'b0, 8'd0, 8'd0, 8'd0);
    step();
    exp_cnt++;
    check("wr_last", bus.out_count, exp_cnt % 256);
    check("wr_empty", bus.out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
